// File: rtl/dpram_fifo_pkg.sv
// Shared sizing defaults for the dual-port-RAM FIFO controller.
package dpram_fifo_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DEPTH   = 1 << DEF_ADDR_W;
  localparam int DEF_COUNT_W = DEF_ADDR_W + 2;
endpackage

// File: rtl/DualportRam_rtl.sv
// Existing 16x8 dual-port RAM: both ports write synchronously, read data registered (1 clk latency).
module DualportRam_rtl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_portA,
  input  logic              wr_enb_portA,
  input  logic [DATA_W-1:0] data_in_portA,
  output logic [DATA_W-1:0] data_out_portA,
  input  logic [ADDR_W-1:0] addr_portB,
  input  logic              wr_enb_portB,
  input  logic [DATA_W-1:0] data_in_portB,
  output logic [DATA_W-1:0] data_out_portB
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_enb_portA) mem[addr_portA] <= data_in_portA;
    if (wr_enb_portB) mem[addr_portB] <= data_in_portB;
    data_out_portA <= mem[addr_portA];
    data_out_portB <= mem[addr_portB];
  end
endmodule

// File: rtl/dpram_fifo_ctrl_skid.sv
// Two-entry output FIFO absorbing RAM read returns; e0 is always the head.
module fifo_skid2
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        cnt
);
  logic [DATA_W-1:0] e0, e1;

  assign head = e0;

  // Caller guarantees no push when full without a pop, and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving DualportRam_rtl: port A writes, port B reads into a 2-entry skid.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic [ADDR_W-1:0] addr_portA,
  output logic              wr_enb_portA,
  output logic [DATA_W-1:0] data_in_portA,
  output logic [ADDR_W-1:0] addr_portB,
  output logic              wr_enb_portB,
  output logic [DATA_W-1:0] data_in_portB,
  input  logic [DATA_W-1:0] data_out_portB
);
  localparam int COUNT_W = ADDR_W + 2;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_inflight;
  logic [1:0]        skid_cnt;
  logic [2:0]        skid_load;
  logic              push, pop, rd_issue, ram_full;

  assign ram_full = (ram_cnt == (ADDR_W+1)'(DEPTH));
  assign s_ready  = !ram_full;
  assign full     = ram_full;
  assign push     = s_valid && s_ready;
  assign m_valid  = (skid_cnt != 2'd0);
  assign pop      = m_valid && m_ready;

  // Issue only against committed RAM words, and only if the skid has room
  // for everything already on its way back (a pop this cycle frees one slot).
  assign skid_load = {1'b0, skid_cnt} + {2'b0, rd_inflight};
  assign rd_issue  = (ram_cnt != '0) && (skid_load < (3'd2 + {2'b0, pop}));

  assign addr_portA    = wr_ptr;
  assign wr_enb_portA  = push;
  assign data_in_portA = s_data;
  assign addr_portB    = rd_ptr;
  assign wr_enb_portB  = 1'b0;
  assign data_in_portB = '0;

  assign count = COUNT_W'(ram_cnt) + COUNT_W'(rd_inflight) + COUNT_W'(skid_cnt);
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      rd_inflight <= rd_issue;
      case ({push, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ;
      endcase
      if (s_valid && !s_ready) ovf_err <= 1'b1;
    end
  end

  fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_inflight),
    .pop   (pop),
    .din   (data_out_portB),
    .head  (m_data),
    .cnt   (skid_cnt)
  );
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl wired to DualportRam_rtl.
module tb_dpram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [AW+1:0] count;
  logic          empty, full, ovf_err;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .empty(empty), .full(full), .ovf_err(ovf_err),
    .addr_portA(addr_a), .wr_enb_portA(we_a), .data_in_portA(din_a),
    .addr_portB(addr_b), .wr_enb_portB(we_b), .data_in_portB(din_b),
    .data_out_portB(dout_b)
  );

  DualportRam_rtl #(.DATA_W(DW), .ADDR_W(AW)) ram (
    .clk(clk),
    .addr_portA(addr_a), .wr_enb_portA(we_a), .data_in_portA(din_a), .data_out_portA(dout_a),
    .addr_portB(addr_b), .wr_enb_portB(we_b), .data_in_portB(din_b), .data_out_portB(dout_b)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (m_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL reset_flags m_valid=%b empty=%b exp 0/1", m_valid, empty); end
    checks++; if (full !== 1'b0 || ovf_err !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL reset_misc full=%b ovf=%b we_a=%b exp 0", full, ovf_err, we_a); end
    checks++; if (we_b !== 1'b0 || din_b !== 8'h00) begin errors++; $display("FAIL portb_tie we_b=%b din_b=%h exp 0/00", we_b, din_b); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL mid_count_pre got %0d exp 5", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 6'd0 || m_valid !== 1'b0 || empty !== 1'b1 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL mid_async_reset count=%0d m_valid=%b empty=%b ovf=%b", count, m_valid, empty, ovf_err);
    end
    @(negedge clk); rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b1;
    @(negedge clk); s_valid = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (m_valid) begin
        seen = 1;
        checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL mid_first_word got %h exp 11", m_data); end
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_timeout m_valid never rose exp 1"); end
  endtask

  task automatic test_single();
    do_reset();
    s_valid = 1'b1; s_data = 8'hCC; m_ready = 1'b1;
    #1;
    checks++; if (we_a !== 1'b1 || addr_a !== 4'd0 || din_a !== 8'hCC) begin
      errors++; $display("FAIL single_write we=%b addr=%0d data=%h exp 1/0/cc", we_a, addr_a, din_a);
    end
    @(negedge clk); s_valid = 1'b0; #1;
    checks++; if (m_valid !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL single_edge0 m_valid=%b we=%b exp 0/0", m_valid, we_a); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL single_edge1 m_valid=%b we=%b exp 0/0", m_valid, we_a); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hCC) begin errors++; $display("FAIL single_edge2 m_valid=%b data=%h exp 1/cc", m_valid, m_data); end
    @(negedge clk); #1;
    checks++; if (empty !== 1'b1 || m_valid !== 1'b0 || we_a !== 1'b0) begin errors++; $display("FAIL single_pop empty=%b m_valid=%b we=%b exp 1/0/0", empty, m_valid, we_a); end
    m_ready = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 16) begin
        checks++; if (count !== 6'd16) begin errors++; $display("FAIL fill_count16 got %0d exp 16", count); end
      end
      s_valid = 1'b1; s_data = 8'(i);
      #1;
      if (i >= 16) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready word %0d got %b exp 1", i, s_ready); end
      end
      @(negedge clk);
    end
    s_valid = 1'b0; #1;
    checks++; if (count !== 6'd18 || full !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full count=%0d full=%b s_ready=%b exp 18/1/0", count, full, s_ready);
    end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b exp 0", ovf_err); end
    s_valid = 1'b1; s_data = 8'hEE; #1;
    checks++; if (we_a !== 1'b0) begin errors++; $display("FAIL ovf_no_write we=%b exp 0", we_a); end
    @(negedge clk); s_valid = 1'b0; #1;
    checks++; if (ovf_err !== 1'b1 || count !== 6'd18 || addr_a !== 4'd2) begin
      errors++; $display("FAIL ovf_sticky ovf=%b count=%0d wr_ptr=%0d exp 1/18/2", ovf_err, count, addr_a);
    end
  endtask

  task automatic test_drain();
    int idx = 0, gaps = 0, bad = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 18; c++) begin
      if (m_valid) begin
        if (m_data !== 8'(idx)) begin bad++; $display("FAIL drain_word %0d got %h exp %h", idx, m_data, 8'(idx)); end
        idx++;
      end else if (idx > 0) gaps++;
      @(negedge clk);
    end
    m_ready = 1'b0; #1;
    checks++; if (idx !== 18) begin errors++; $display("FAIL drain_count got %0d exp 18", idx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL drain_order bad %0d exp 0", bad); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL drain_gaps got %0d exp 0", gaps); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_stream();
    int pidx = 0, oidx = 0, gaps = 0, bad = 0, addr_bad = 0, wrap_b = 0;
    logic [AW-1:0] prev_b;
    do_reset();
    m_ready = 1'b1;
    prev_b = addr_b;
    for (int c = 0; c < 80 && oidx < 40; c++) begin
      if (m_valid) begin
        if (m_data !== 8'(8'hA0 + oidx)) begin bad++; $display("FAIL stream_word %0d got %h exp %h", oidx, m_data, 8'(8'hA0 + oidx)); end
        oidx++;
      end else if (oidx > 0) gaps++;
      if (prev_b == 4'd15 && addr_b == 4'd0) wrap_b++;
      prev_b = addr_b;
      if (pidx < 40) begin
        s_valid = 1'b1; s_data = 8'(8'hA0 + pidx); #1;
        if (!we_a || addr_a !== 4'(pidx % 16)) addr_bad++;
        pidx++;
      end else s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0; m_ready = 1'b0; #1;
    checks++; if (oidx !== 40) begin errors++; $display("FAIL stream_count got %0d exp 40", oidx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stream_order bad %0d exp 0", bad); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL stream_gaps got %0d exp 0", gaps); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL stream_wr_addr bad %0d exp 0", addr_bad); end
    checks++; if (wrap_b !== 2) begin errors++; $display("FAIL stream_rd_wrap got %0d exp 2", wrap_b); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b exp 1", empty); end
  endtask

  task automatic test_backpressure();
    int pidx = 0, oidx = 0, bad = 0, hold_bad = 0, cnt_bad = 0, rdy_bad = 0;
    logic [3:0] pat = 4'b1001;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    do_reset();
    for (int c = 0; c < 120 && oidx < 20; c++) begin
      m_ready = pat[c % 4];
      if (count > 6'd18) cnt_bad++;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) hold_bad++;
      if (m_valid && m_ready) begin
        if (m_data !== 8'(8'h30 + oidx)) begin bad++; $display("FAIL bp_word %0d got %h exp %h", oidx, m_data, 8'(8'h30 + oidx)); end
        oidx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (pidx < 20) begin
        s_valid = 1'b1; s_data = 8'(8'h30 + pidx); #1;
        if (s_ready !== 1'b1) rdy_bad++;
        pidx++;
      end else s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0; m_ready = 1'b0; #1;
    checks++; if (oidx !== 20) begin errors++; $display("FAIL bp_count got %0d exp 20", oidx); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_order bad %0d exp 0", bad); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold bad %0d exp 0", hold_bad); end
    checks++; if (cnt_bad !== 0 || rdy_bad !== 0) begin errors++; $display("FAIL bp_limits cnt_bad=%0d rdy_bad=%0d exp 0/0", cnt_bad, rdy_bad); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty got %b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_fill();
    test_drain();
    test_stream();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
